// File: rtl/counter_ext.sv
// -----------------------------------------------------------------------------
// counter_ext -- parametrised event/timebase counter
//
// An up/down counter with enable, synchronous clear and load, a programmable
// terminal value (count range 0..limit), wrap or saturate behaviour at the
// boundary, a clock prescaler and a registered terminal-count pulse.
//
// Parameters
//   WIDTH      : width of count, load_val and limit (2..32)
//   PRESCALE_W : width of the prescaler divide field (1..16)
//   SATURATE   : 0 = wrap at the boundary, 1 = clamp at the boundary
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : count enable, gates the prescaler
//   up_dn    : direction, 1 = up, 0 = down (sampled on each tick)
//   clear    : synchronous clear of count and prescaler (highest priority)
//   load     : synchronous load of load_val
//   load_val : value written by load (may exceed limit)
//   limit    : terminal value
//   prescale : a tick occurs every prescale+1 enabled cycles
//   out      : current count, registered
//   tc       : one-cycle terminal-count pulse, registered, aligned with out
//   sat      : high while parked at the boundary (SATURATE=1 only)
// -----------------------------------------------------------------------------
module counter_ext #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4,
   parameter int SATURATE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      out,
   output logic                  tc,
   output logic                  sat
);

   logic [PRESCALE_W-1:0] pre_reg, pre_next;
   logic [WIDTH-1:0]      out_reg, out_next;
   logic                  tc_reg, tc_next;

   logic                  tick;
   logic                  at_top;
   logic                  at_zero;
   logic [WIDTH-1:0]      inc_val;
   logic [WIDTH-1:0]      dec_val;

   // Candidate next values for a tick in each direction, chosen by mode.
   logic [WIDTH-1:0]      up_val, dn_val;
   logic                  up_tc, dn_tc;
   logic                  sat_level;

   assign at_top  = (out_reg >= limit);
   assign at_zero = (out_reg == '0);
   assign inc_val = out_reg + WIDTH'(1);
   assign dec_val = out_reg - WIDTH'(1);

   // Equality compare (not >=) so a prescale lowered below the current phase
   // lets pre run on and wrap naturally instead of forcing an early tick.
   assign tick = en && (pre_reg == prescale);

   generate
      if (SATURATE != 0) begin : g_sat
         always_comb begin
            up_val = limit;
            up_tc  = 1'b0;
            dn_val = '0;
            dn_tc  = 1'b0;
            if (!at_top) begin
               up_val = inc_val;
               // Pulse only on arrival at the boundary, never while parked.
               up_tc  = (inc_val == limit);
            end
            if (!at_zero) begin
               dn_val = dec_val;
               dn_tc  = (out_reg == WIDTH'(1));
            end
         end
         assign sat_level = (up_dn && at_top) || (!up_dn && at_zero);
      end else begin : g_wrap
         always_comb begin
            up_val = '0;
            up_tc  = 1'b1;
            dn_val = limit;
            dn_tc  = 1'b1;
            if (!at_top) begin
               up_val = inc_val;
               up_tc  = 1'b0;
            end
            if (!at_zero) begin
               dn_val = dec_val;
               dn_tc  = 1'b0;
            end
         end
         assign sat_level = 1'b0;
      end
   endgenerate

   // Next-state selection: clear > load > tick > hold.
   always_comb begin
      pre_next = pre_reg;
      out_next = out_reg;
      tc_next  = 1'b0;
      if (clear) begin
         pre_next = '0;
         out_next = '0;
      end else if (load) begin
         pre_next = '0;
         out_next = load_val;
      end else if (en) begin
         if (tick) begin
            pre_next = '0;
            if (up_dn) begin
               out_next = up_val;
               tc_next  = up_tc;
            end else begin
               out_next = dn_val;
               tc_next  = dn_tc;
            end
         end else begin
            pre_next = pre_reg + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_reg <= '0;
         out_reg <= '0;
         tc_reg  <= 1'b0;
      end else begin
         pre_reg <= pre_next;
         out_reg <= out_next;
         tc_reg  <= tc_next;
      end
   end

   assign out = out_reg;
   assign tc  = tc_reg;
   assign sat = sat_level;

endmodule

// File: tb/tb_counter_ext.sv
// -----------------------------------------------------------------------------
// tb_counter_ext -- self-checking bench for counter_ext
//
// Two instances share all inputs: one in wrap mode, one in saturate mode,
// both WIDTH=4. A behavioural integer model of each tracks the expected
// count, prescaler phase and tc pulse; outputs are compared on the falling
// edge. Directed steps follow the test plan, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_counter_ext;

   localparam int W    = 4;
   localparam int PW   = 4;
   localparam int PMOD = 1 << PW;

   logic          clk;
   logic          rst;
   logic          en;
   logic          up_dn;
   logic          clear;
   logic          load;
   logic [W-1:0]  load_val;
   logic [W-1:0]  limit;
   logic [PW-1:0] prescale;

   logic [W-1:0]  out_w, out_s;
   logic          tc_w, tc_s, sat_w, sat_s;

   int checks   = 0;
   int failures = 0;

   // Model state, index 0 = wrap instance, 1 = saturate instance.
   int m_out[2];
   int m_pre[2];
   int m_tc[2];

   counter_ext #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
      .load(load), .load_val(load_val), .limit(limit), .prescale(prescale),
      .out(out_w), .tc(tc_w), .sat(sat_w)
   );

   counter_ext #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
      .load(load), .load_val(load_val), .limit(limit), .prescale(prescale),
      .out(out_s), .tc(tc_s), .sat(sat_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_out[d] = 0;
         m_pre[d] = 0;
         m_tc[d]  = 0;
      end
   endtask

   // Applies the counter rules for one rising edge using the current inputs.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         bit tick;
         int lim;
         tick = 0;
         lim  = int'(limit);
         if (rst || clear) begin
            m_out[d] = 0;
            m_pre[d] = 0;
            m_tc[d]  = 0;
         end else if (load) begin
            m_out[d] = int'(load_val);
            m_pre[d] = 0;
            m_tc[d]  = 0;
         end else begin
            m_tc[d] = 0;
            if (en) begin
               if (m_pre[d] == int'(prescale)) begin
                  tick     = 1;
                  m_pre[d] = 0;
               end else begin
                  m_pre[d] = (m_pre[d] + 1) % PMOD;
               end
            end
            if (tick) begin
               if (up_dn) begin
                  if (m_out[d] < lim) begin
                     m_out[d] = m_out[d] + 1;
                     m_tc[d]  = (d == 1 && m_out[d] == lim) ? 1 : 0;
                  end else if (d == 1) begin
                     m_out[d] = lim;
                  end else begin
                     m_out[d] = 0;
                     m_tc[d]  = 1;
                  end
               end else begin
                  if (m_out[d] > 0) begin
                     m_out[d] = m_out[d] - 1;
                     m_tc[d]  = (d == 1 && m_out[d] == 0) ? 1 : 0;
                  end else if (d == 0) begin
                     m_out[d] = lim;
                     m_tc[d]  = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all();
      int exp_sat;
      chk("wrap_out", 32'(out_w), 32'(m_out[0]));
      chk("wrap_tc",  32'(tc_w),  32'(m_tc[0]));
      chk("wrap_sat", 32'(sat_w), 32'(0));
      chk("sat_out",  32'(out_s), 32'(m_out[1]));
      chk("sat_tc",   32'(tc_s),  32'(m_tc[1]));
      exp_sat = ((up_dn && m_out[1] >= int'(limit)) || (!up_dn && m_out[1] == 0)) ? 1 : 0;
      chk("sat_sat",  32'(sat_s), 32'(exp_sat));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
      load_val = '0; limit = '0; prescale = '0;
      model_reset();
      repeat (3) cycle();
      rst = 1'b0;
      chk("reset_out", 32'(out_w), 32'(0));
      chk("reset_tc", 32'(tc_w), 32'(0));

      // 1: basic wrap 0..9,0
      $display("step 1: basic wrap limit=9");
      limit = 4'd9; prescale = '0; en = 1'b1; up_dn = 1'b1;
      repeat (10) cycle();
      chk("t1_out_wrapped", 32'(out_w), 32'(0));
      chk("t1_tc_on_wrap", 32'(tc_w), 32'(1));
      cycle();
      chk("t1_tc_one_cycle", 32'(tc_w), 32'(0));

      // 2: prescale and enable gap
      $display("step 2: prescale=2 with enable gap");
      clear = 1'b1; cycle(); clear = 1'b0;
      limit = 4'd15; prescale = 4'd2;
      repeat (7) cycle();
      en = 1'b0;
      repeat (5) cycle();
      chk("t2_hold_out", 32'(out_w), 32'(2));
      en = 1'b1;
      repeat (6) cycle();
      chk("t2_resume_out", 32'(out_w), 32'(4));

      // 3: down wrap after load
      $display("step 3: load 3, count down, limit=5");
      prescale = '0; load_val = 4'd3; load = 1'b1; cycle(); load = 1'b0;
      up_dn = 1'b0; limit = 4'd5;
      repeat (4) cycle();
      chk("t3_down_wrap_out", 32'(out_w), 32'(5));
      chk("t3_down_wrap_tc", 32'(tc_w), 32'(1));
      cycle();
      chk("t3_after_wrap", 32'(out_w), 32'(4));

      // 4: saturate at limit, then reverse
      $display("step 4: saturate limit=6");
      clear = 1'b1; cycle(); clear = 1'b0;
      up_dn = 1'b1; limit = 4'd6;
      repeat (8) cycle();
      chk("t4_parked", 32'(out_s), 32'(6));
      chk("t4_sat_high", 32'(sat_s), 32'(1));
      up_dn = 1'b0;
      #1;
      chk("t4_sat_drop", 32'(sat_s), 32'(0));
      repeat (2) cycle();
      chk("t4_down", 32'(out_s), 32'(4));

      // 5: priority and load above limit
      $display("step 5: clear/load priority, load above limit");
      up_dn = 1'b1; limit = 4'd9;
      clear = 1'b1; load = 1'b1; load_val = 4'd5; cycle();
      chk("t5_clear_wins", 32'(out_w), 32'(0));
      clear = 1'b0; load_val = 4'd12; cycle();
      chk("t5_load_12", 32'(out_w), 32'(12));
      load = 1'b0; cycle();
      chk("t5_over_wrap_out", 32'(out_w), 32'(0));
      chk("t5_over_wrap_tc", 32'(tc_w), 32'(1));
      chk("t5_over_clamp", 32'(out_s), 32'(9));

      // 6: async reset mid-count
      $display("step 6: async reset at out=7");
      clear = 1'b1; cycle(); clear = 1'b0;
      repeat (7) cycle();
      chk("t6_pre_reset", 32'(out_w), 32'(7));
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("t6_async_out", 32'(out_w), 32'(0));
      chk("t6_async_tc", 32'(tc_w), 32'(0));
      check_all();
      #1 rst = 1'b0;
      prescale = 4'd2;
      repeat (2) cycle();
      chk("t6_no_early_tick", 32'(out_w), 32'(0));
      cycle();
      chk("t6_first_tick", 32'(out_w), 32'(1));

      // Randomized phase
      $display("step 7: randomized stimulus");
      for (int n = 0; n < 1500; n++) begin
         rst      = ($urandom_range(0, 199) == 0);
         clear    = ($urandom_range(0, 39) == 0);
         load     = ($urandom_range(0, 24) == 0);
         en       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
         load_val = W'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) limit = W'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) prescale = PW'($urandom_range(0, 3));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
